// File: rtl/alu_trace_buffer_if.sv
// Capture and drain bus of the ALU trace buffer.
// master = CPU/consumer side, slave = buffer side.
interface alu_trace_buffer_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          cap_valid;
  logic [DW-1:0] alu_f;
  logic          zf;
  logic          of;
  logic          clr;
  logic          rd_en;
  logic [DW+9:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic [15:0]   drop_cnt;

  modport master (
    output cap_valid, alu_f, zf, of, clr, rd_en,
    input  rd_data, rd_valid, empty, full, level, drop_cnt
  );

  modport slave (
    input  cap_valid, alu_f, zf, of, clr, rd_en,
    output rd_data, rd_valid, empty, full, level, drop_cnt
  );
endinterface

// File: rtl/alu_trace_buffer.sv
// Trace FIFO of per-instruction ALU results tagged with a sequence number.
// Drop-when-full or overwrite-oldest, with a saturating loss counter.
module alu_trace_buffer #(
  parameter int DW        = 32,
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b0
) (
  input logic clk,
  input logic rst,
  alu_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + 10;
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_seq;
  logic [15:0]   r_drop;
  logic [EW-1:0] r_rd_data;
  logic          r_rd_valid;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_lost;
  logic          w_push;
  logic          w_ovr;
  logic [EW-1:0] w_entry;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == L_FULL);
  assign w_pop   = bus.rd_en & ~w_empty & ~bus.clr;
  // a capture into a full buffer with no pop loses an entry
  assign w_lost  = bus.cap_valid & w_full & ~w_pop & ~bus.clr;
  assign w_ovr   = w_lost & OVERWRITE;
  assign w_push  = bus.cap_valid & ~bus.clr & ~(w_lost & ~OVERWRITE);
  assign w_entry = {r_seq, bus.of, bus.zf, bus.alu_f};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_seq      <= '0;
      r_drop     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (bus.clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_seq      <= '0;
      r_drop     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rptr];
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop | w_ovr) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push & ~w_pop & ~w_ovr) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop & ~w_push) begin
        r_level <= r_level - 1'b1;
      end
      if (bus.cap_valid) begin
        r_seq <= r_seq + 8'd1;
      end
      if (w_lost && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.level    = r_level;
  assign bus.drop_cnt = r_drop;
endmodule

// File: tb/tb_alu_trace_buffer.sv
// Bench: drop-mode and overwrite-mode buffers share stimulus and are
// checked every cycle against a queue model, plus literal checks.
module tb_alu_trace_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int EW    = DW + 10;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef logic [EW-1:0] ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cap = 1'b0;
  logic [31:0] alu = '0;
  logic        zf  = 1'b0;
  logic        of  = 1'b0;
  logic        clr = 1'b0;
  logic        rd  = 1'b0;

  int total = 0;
  int bad   = 0;

  alu_trace_buffer_if #(.DW(DW), .DEPTH(DEPTH)) if0 ();
  alu_trace_buffer_if #(.DW(DW), .DEPTH(DEPTH)) if1 ();

  assign if0.cap_valid = cap;
  assign if0.alu_f     = alu;
  assign if0.zf        = zf;
  assign if0.of        = of;
  assign if0.clr       = clr;
  assign if0.rd_en     = rd;
  assign if1.cap_valid = cap;
  assign if1.alu_f     = alu;
  assign if1.zf        = zf;
  assign if1.of        = of;
  assign if1.clr       = clr;
  assign if1.rd_en     = rd;

  alu_trace_buffer #(
    .DW(DW), .DEPTH(DEPTH), .OVERWRITE(1'b0)
  ) u_drop (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );

  alu_trace_buffer #(
    .DW(DW), .DEPTH(DEPTH), .OVERWRITE(1'b1)
  ) u_ovw (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  ent_t          d_data  [2];
  logic          d_valid [2];
  logic          d_empty [2];
  logic          d_full  [2];
  logic [LW-1:0] d_level [2];
  logic [15:0]   d_drop  [2];

  always_comb begin
    d_data[0]  = if0.rd_data;
    d_valid[0] = if0.rd_valid;
    d_empty[0] = if0.empty;
    d_full[0]  = if0.full;
    d_level[0] = if0.level;
    d_drop[0]  = if0.drop_cnt;
    d_data[1]  = if1.rd_data;
    d_valid[1] = if1.rd_valid;
    d_empty[1] = if1.empty;
    d_full[1]  = if1.full;
    d_level[1] = if1.level;
    d_drop[1]  = if1.drop_cnt;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // queue model: index 0 drops when full, index 1 overwrites oldest
  ent_t       mq [2][$];
  ent_t       m_data  [2];
  logic       m_valid [2];
  int         m_drop  [2];
  logic [7:0] m_seq;

  always @(posedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        mq[m].delete();
        m_data[m]  = '0;
        m_valid[m] = 1'b0;
        m_drop[m]  = 0;
      end
      m_seq = 8'd0;
    end else if (clr) begin
      for (int m = 0; m < 2; m++) begin
        mq[m].delete();
        m_valid[m] = 1'b0;
        m_drop[m]  = 0;
      end
      m_seq = 8'd0;
    end else begin
      ent_t e;
      e = {m_seq, of, zf, alu};
      for (int m = 0; m < 2; m++) begin
        bit was_full;
        bit pop;
        was_full = (mq[m].size() == DEPTH);
        pop = rd && (mq[m].size() > 0);
        m_valid[m] = pop;
        if (pop) m_data[m] = mq[m].pop_front();
        if (cap) begin
          if (!was_full || pop) begin
            mq[m].push_back(e);
          end else begin
            if (m_drop[m] < 65535) m_drop[m]++;
            if (m == 1) begin
              void'(mq[m].pop_front());
              mq[m].push_back(e);
            end
          end
        end
      end
      if (cap) m_seq = m_seq + 8'd1;
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rd_valid[%0d]", m), d_valid[m], m_valid[m]);
      chk($sformatf("rd_data[%0d]", m), d_data[m], m_data[m]);
      chk($sformatf("level[%0d]", m), d_level[m], mq[m].size());
      chk($sformatf("empty[%0d]", m), d_empty[m], mq[m].size() == 0);
      chk($sformatf("full[%0d]", m), d_full[m], mq[m].size() == DEPTH);
      chk($sformatf("drop_cnt[%0d]", m), d_drop[m], m_drop[m]);
    end
  end

  task automatic step(input logic c, input logic [31:0] a, input logic z,
                      input logic o, input logic r, input logic cl);
    @(negedge clk);
    cap = c;
    alu = a;
    zf  = z;
    of  = o;
    rd  = r;
    clr = cl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    ent_t e0;
    ent_t e1;
    int   n;
    logic c;
    logic r;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset level", d_level[0], 0);
    chk("reset empty", d_empty[1], 1);
    chk("reset rd_data", d_data[0], 0);
    @(negedge clk);
    rst = 1'b1;

    // build level 3 with a popped entry, then reset mid-cycle
    for (int i = 0; i < 4; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre-reset level", d_level[0], 3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("async level", d_level[m], 0);
      chk("async empty", d_empty[m], 1);
      chk("async full", d_full[m], 0);
      chk("async rd_data", d_data[m], 0);
      chk("async rd_valid", d_valid[m], 0);
      chk("async drop", d_drop[m], 0);
    end
    @(negedge clk);
    rst = 1'b1;

    step(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      chk("first pop valid", d_valid[m], 1);
      chk("first pop data", d_data[m], 42'h0_0000_0005);
    end

    // fill/drain and overwrite
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      chk("fill full", d_full[m], 1);
      chk("fill level", d_level[m], 4);
    end
    step(1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop after 5 [0]", d_drop[0], 1);
    chk("drop after 5 [1]", d_drop[1], 1);
    step(1'b1, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop after 6 [1]", d_drop[1], 2);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      e0 = {8'(k), 2'b00, 32'(k + 1)};
      e1 = {8'(k + 2), 2'b00, 32'(k + 3)};
      chk("drain drop-mode", d_data[0], e0);
      chk("drain ovw-mode", d_data[1], e1);
    end
    chk("drained empty", d_empty[0], 1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty pop valid", d_valid[0], 0);

    // push and pop together while full
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd14, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      chk("full pushpop level", d_level[m], 4);
      chk("full pushpop drop", d_drop[m], 0);
      chk("full pushpop data", d_data[m], {8'd0, 2'b00, 32'd10});
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      e0 = {8'(k + 1), 2'b00, 32'(11 + k)};
      chk("after pushpop [0]", d_data[0], e0);
      chk("after pushpop [1]", d_data[1], e0);
    end

    // clr beats a same-cycle capture and pop
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'd20, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd21, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd22, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int m = 0; m < 2; m++) begin
      chk("clr level", d_level[m], 0);
      chk("clr empty", d_empty[m], 1);
      chk("clr rd_valid", d_valid[m], 0);
      chk("clr drop", d_drop[m], 0);
      chk("clr holds rd_data", d_data[m], {8'd4, 2'b00, 32'd14});
    end
    step(1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flags entry [0]", d_data[0], 42'h3_0000_0000);
    chk("flags entry [1]", d_data[1], 42'h3_0000_0000);

    // random traffic across a full sequence wrap
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (n < 256) begin
      c = ($urandom_range(0, 99) < 60);
      r = 1'($urandom_range(0, 1));
      step(c, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
           1'($urandom), 1'($urandom), r, 1'b0);
      if (c) n++;
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap drained", d_empty[1], 1);
    step(1'b1, 32'hABCD, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("seq wrap [0]", d_data[0], {8'h00, 2'b00, 32'h0000_ABCD});
    chk("seq wrap [1]", d_data[1], {8'h00, 2'b00, 32'h0000_ABCD});

    // drop counter saturation
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65545; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop sat [0]", d_drop[0], 16'hFFFF);
    chk("drop sat [1]", d_drop[1], 16'hFFFF);

    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
